// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, in-order instruction buffer and flush-on-redirect fetch stage
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0]    alloc_ptr, fill_ptr, read_ptr, occupancy;
    logic [CW-1:0]    discard;
    logic             issue, pop;

    assign occupancy   = alloc_ptr - read_ptr;
    // discarded responses still hold a memory slot, so they count against credits
    assign imem_req    = !reset && !redirect_valid && (32'(occupancy) + 32'(discard) < 32'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign instr_valid = !reset && !redirect_valid && occupancy != '0 && filled[read_ptr[AW-1:0]];
    assign instruction = instr_valid ? data_q[read_ptr[AW-1:0]] : NOP;
    assign instr_pc    = instr_valid ? pc_q[read_ptr[AW-1:0]] : 32'h0;
    assign issue       = imem_req && imem_ready;
    assign pop         = instr_valid && instr_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            read_ptr  <= '0;
            filled    <= '0;
            discard   <= '0;
        end else if (redirect_valid) begin
            fetch_pc  <= redirect_pc & ~32'h3;
            alloc_ptr <= read_ptr;
            fill_ptr  <= read_ptr;
            filled    <= '0;
            discard   <= discard + CW'(alloc_ptr - fill_ptr) - CW'(imem_rvalid);
        end else begin
            if (issue) begin
                pc_q[alloc_ptr[AW-1:0]]   <= fetch_pc;
                filled[alloc_ptr[AW-1:0]] <= 1'b0;
                alloc_ptr                 <= alloc_ptr + PW'(1);
                fetch_pc                  <= fetch_pc + 32'd4;
            end
            if (imem_rvalid && discard != '0) begin
                discard <= discard - CW'(1);
            end else if (imem_rvalid) begin
                data_q[fill_ptr[AW-1:0]] <= imem_rdata;
                filled[fill_ptr[AW-1:0]] <= 1'b1;
                fill_ptr                 <= fill_ptr + PW'(1);
            end
            if (pop) begin
                filled[read_ptr[AW-1:0]] <= 1'b0;
                read_ptr                 <= read_ptr + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench; memory returns addr ^ K after a programmable latency
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] K   = 32'h1357_9BDF;

    logic        clock = 0, reset = 1;
    logic        imem_req, imem_ready = 0, imem_rvalid = 0;
    logic [31:0] imem_addr, imem_rdata = 0;
    logic        redirect_valid = 0, instr_valid, instr_ready = 0;
    logic [31:0] redirect_pc = 0, instruction, instr_pc;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc)
    );

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    int          n_cmp = 0, n_err = 0, cyc = 0;
    int          lat = 1, allow = 0, n_acc = 0, a0;
    logic        mem_hold = 0, held = 0;
    logic [31:0] held_pc, w;
    logic [31:0] exp_q[$];
    rsp_t        mq[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // memory model: in-order responses, cleared together with the DUT on reset
    initial forever begin
        @(negedge clock); #1;
        imem_ready = allow > 0 && !mem_hold;
        if (reset) begin
            mq.delete();
            imem_rvalid = 0;
        end else begin
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rvalid = 1;
                imem_rdata  = mq[0].addr ^ K;
                void'(mq.pop_front());
            end else begin
                imem_rvalid = 0;
                imem_rdata  = 0;
            end
            if (imem_req && imem_ready) begin
                mq.push_back('{imem_addr, cyc + lat});
                allow--;
                n_acc++;
            end
        end
    end

    // monitor: pops expected PCs on each handshake and checks output stability under stall
    initial forever begin
        @(negedge clock); #3;
        if (held && !reset && !redirect_valid) chk("hold_pc", instr_pc, held_pc);
        if (!reset && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_instr: got pc %h, expected no delivery", instr_pc);
            end else begin
                w = exp_q.pop_front();
                chk("instr_pc", instr_pc, w);
                chk("instruction", instruction, w ^ K);
            end
        end
        held    = instr_valid && !instr_ready;
        held_pc = instr_pc;
    end

    task automatic drain();
        int i = 0;
        while ((exp_q.size() > 0 || mq.size() > 0) && i < 60) begin
            @(negedge clock);
            i++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clock);
        #4;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", instr_pc, 0);
        // streaming: 1-cycle memory, decode always ready
        @(negedge clock);
        reset = 0; instr_ready = 1; allow = 8;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(4 * i));
        for (int c = 1; c <= 10; c++) begin
            #4;
            if (c == 1) begin
                chk("s_req", 32'(imem_req), 1);
                chk("s_addr", imem_addr, 0);
            end
            if (c == 2) chk("s_valid_c2", 32'(instr_valid), 0);
            if (c >= 3) begin
                chk("s_valid", 32'(instr_valid), 1);
                chk("s_pc", instr_pc, 32'(4 * (c - 3)));
            end
            @(negedge clock);
        end
        drain();
        // decode stall: credits cap outstanding requests at DEPTH
        instr_ready = 0; allow = 6; a0 = n_acc;
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h20 + 32'(4 * i));
        repeat (6) @(negedge clock);
        #4;
        chk("stall_acc", 32'(n_acc - a0), 32'(DEPTH));
        chk("stall_req", 32'(imem_req), 0);
        chk("stall_valid", 32'(instr_valid), 1);
        chk("stall_pc", instr_pc, 32'h20);
        @(negedge clock);
        instr_ready = 1;
        drain();
        // memory not ready: address holds
        mem_hold = 1; allow = 2;
        exp_q.push_back(32'h38); exp_q.push_back(32'h3C);
        for (int c = 0; c < 3; c++) begin
            #4;
            chk("hold_req", 32'(imem_req), 1);
            chk("hold_addr", imem_addr, 32'h38);
            @(negedge clock);
        end
        mem_hold = 0;
        #4 chk("hold_addr_acc", imem_addr, 32'h38);
        @(negedge clock);
        drain();
        // redirect with two requests in flight, 3-cycle latency
        lat = 3; allow = 2;
        repeat (2) @(negedge clock);
        redirect_valid = 1; redirect_pc = 32'h100;
        exp_q.delete(); exp_q.push_back(32'h100); exp_q.push_back(32'h104); allow = 2;
        #4 chk("rd_req", 32'(imem_req), 0);
        @(negedge clock);
        redirect_valid = 0;
        #4;
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_stale_rvalid", 32'(imem_rvalid), 1);
        @(negedge clock);
        drain();
        lat = 1;
        // unaligned redirect target
        redirect_valid = 1; redirect_pc = 32'h203; allow = 1;
        exp_q.push_back(32'h200);
        @(negedge clock);
        redirect_valid = 0;
        #4;
        chk("ua_req", 32'(imem_req), 1);
        chk("ua_addr", imem_addr, 32'h200);
        @(negedge clock);
        drain();
        // redirect coinciding with a response and a valid head
        allow = 2;
        repeat (2) @(negedge clock);
        #2;
        chk("co_rvalid", 32'(imem_rvalid), 1);
        chk("co_valid_pre", 32'(instr_valid), 1);
        chk("co_pc_pre", instr_pc, 32'h204);
        redirect_valid = 1; redirect_pc = 32'h300;
        exp_q.delete(); exp_q.push_back(32'h300); exp_q.push_back(32'h304); allow = 2;
        #2;
        chk("co_valid", 32'(instr_valid), 0);
        chk("co_instr", instruction, NOP);
        chk("co_req", 32'(imem_req), 0);
        @(negedge clock);
        redirect_valid = 0;
        drain();
        // reset with a full buffer
        instr_ready = 0; allow = 4;
        repeat (7) @(negedge clock);
        #4;
        chk("full_valid", 32'(instr_valid), 1);
        chk("full_req", 32'(imem_req), 0);
        chk("full_pc", instr_pc, 32'h308);
        @(negedge clock);
        reset = 1;
        #4;
        chk("mr_req", 32'(imem_req), 0);
        chk("mr_valid", 32'(instr_valid), 0);
        chk("mr_instr", instruction, NOP);
        chk("mr_pc", instr_pc, 0);
        @(negedge clock);
        reset = 0; instr_ready = 1; allow = 2;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        #4;
        chk("ar_valid", 32'(instr_valid), 0);
        chk("ar_instr", instruction, NOP);
        chk("ar_addr", imem_addr, 0);
        chk("ar_req", 32'(imem_req), 1);
        @(negedge clock);
        drain();
        // PC wrap
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; allow = 2;
        exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
        @(negedge clock);
        redirect_valid = 0;
        #4 chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clock);
        #4 chk("wrap_addr1", imem_addr, 32'h0);
        @(negedge clock);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
